// File: rtl/mux_4bit_rr_arbiter_if.sv
// mux_4bit_rr_arbiter_if: request/output bus of the round-robin arbiter.
interface mux_4bit_rr_arbiter_if #(parameter int DATA_W = 4);
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] data_c;
    logic [DATA_W-1:0] data_d;
    logic [1:0]        sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    modport master (
        output req_valid, data_a, data_b, data_c, data_d, out_ready,
        input  req_ready, sel, out_valid, out_data, out_src
    );
    modport slave (
        input  req_valid, data_a, data_b, data_c, data_d, out_ready,
        output req_ready, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_4bit_rr_arbiter.sv
// mux_4bit_rr_arbiter: round-robin burst arbiter feeding a one-word output register.
// Define MUX_ARB_PRIO_A_EN to give requester a absolute priority.
module mux_4bit_rr_arbiter #(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_4bit_rr_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    localparam logic [3:0] MB = 4'(MAX_BURST);
    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_data, w_data;
    logic [1:0]        r_src, r_last, w_scan, w_win, w_k;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_can_accept, w_grant, w_hold, w_found, w_prio_a;
`ifdef MUX_ARB_PRIO_A_EN
    assign w_prio_a = bus.req_valid[0];
`else
    assign w_prio_a = 1'b0;
`endif
    assign w_can_accept = (r_state == EMPTY) || bus.out_ready;
    assign w_grant      = w_can_accept && (|bus.req_valid) && !rst;
    // r_cnt==0 means no burst is running yet, so the reset pointer never holds
    assign w_hold = bus.req_valid[r_last] && (r_cnt != 4'd0) && (r_cnt < MB);
    always_comb begin
        w_scan  = r_last;
        w_found = 1'b0;
        w_k     = r_last;
        for (int i = 1; i <= 4; i++) begin
            w_k = r_last + 2'(i);
            if (!w_found && bus.req_valid[w_k]) begin
                w_scan  = w_k;
                w_found = 1'b1;
            end
        end
    end
    assign w_win     = w_prio_a ? 2'd0 : (w_hold ? r_last : w_scan);
    assign w_cnt_nxt = w_prio_a ? 4'd0 :
                       (w_win != r_last) ? 4'd1 :
                       (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
    assign w_data = (w_win == 2'd0) ? bus.data_a :
                    (w_win == 2'd1) ? bus.data_b :
                    (w_win == 2'd2) ? bus.data_c : bus.data_d;
    assign bus.req_ready = w_grant ? (4'b0001 << w_win) : 4'b0000;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;
    assign bus.sel       = r_src;
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_grant ? FULL :
                      (r_state == FULL && bus.out_ready) ? EMPTY : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_src  <= 2'd0;
            r_last <= 2'd3;
            r_cnt  <= 4'd0;
        end else if (w_grant) begin
            r_data <= w_data;
            r_src  <= w_win;
            r_last <= w_win;
            r_cnt  <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_mux_4bit_rr_arbiter.sv
// tb_mux_4bit_rr_arbiter: table-driven scoreboard bench for MAX_BURST=1 and MAX_BURST=3 arbiters.
module tb_mux_4bit_rr_arbiter;
    typedef struct packed {
        logic [3:0] v;
        logic       ordy;
        logic       g;
        logic [1:0] w;
    } vec_t;
    typedef struct packed {
        logic [1:0] src;
        logic [3:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       u = 1'b0;
    logic [3:0] vld = 4'd0;
    logic       ordy_r = 1'b1;
    logic [3:0] da = 4'd0, db = 4'd0, dc = 4'd0, dd = 4'd0;
    logic [3:0] o_rdy, o_data;
    logic [1:0] o_src, o_sel;
    logic       o_valid;
    int         n_tests = 0;
    int         n_fail = 0;
    exp_t       q[$];
    vec_t       t1[9];
    vec_t       t2[8];

    mux_4bit_rr_arbiter_if #(.DATA_W(4)) b1 ();
    mux_4bit_rr_arbiter_if #(.DATA_W(4)) b3 ();

    mux_4bit_rr_arbiter #(.DATA_W(4), .MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mux_4bit_rr_arbiter #(.DATA_W(4), .MAX_BURST(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    assign b1.req_valid = vld;
    assign b1.out_ready = ordy_r;
    assign b1.data_a = da;
    assign b1.data_b = db;
    assign b1.data_c = dc;
    assign b1.data_d = dd;
    assign b3.req_valid = vld;
    assign b3.out_ready = ordy_r;
    assign b3.data_a = da;
    assign b3.data_b = db;
    assign b3.data_c = dc;
    assign b3.data_d = dd;

    always_comb begin
        o_rdy   = u ? b3.req_ready : b1.req_ready;
        o_data  = u ? b3.out_data  : b1.out_data;
        o_src   = u ? b3.out_src   : b1.out_src;
        o_sel   = u ? b3.sel       : b1.sel;
        o_valid = u ? b3.out_valid : b1.out_valid;
    end

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dsel(input logic [1:0] w);
        return (w == 2'd0) ? da : (w == 2'd1) ? db : (w == 2'd2) ? dc : dd;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        vld = 4'd0;
        ordy_r = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        chk("reset_out_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_out_data", {28'd0, o_data}, 32'd0);
        chk("reset_sel", {30'd0, o_sel}, 32'd0);
    endtask

    // Output side is checked against the queue head before this cycle's grant is pushed.
    task automatic step(input logic [3:0] v, input logic ordy, input logic g, input logic [1:0] w);
        vld = v;
        ordy_r = ordy;
        #1;
        chk("out_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_src", {30'd0, o_src}, {30'd0, q[0].src});
            chk("out_data", {28'd0, o_data}, {28'd0, q[0].data});
            chk("sel", {30'd0, o_sel}, {30'd0, q[0].src});
            if (ordy) void'(q.pop_front());
        end
        chk("req_ready", {28'd0, o_rdy}, {28'd0, g ? (4'b0001 << w) : 4'b0000});
        if (g) q.push_back('{src: w, data: dsel(w)});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input vec_t t);
        step(t.v, t.ordy, t.g, t.w);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) t1[i] = '{v: 4'hF, ordy: 1'b1, g: 1'b1, w: 2'(i % 4)};
        for (int i = 0; i < 8; i++) t2[i] = '{v: 4'b0110, ordy: 1'b1, g: 1'b1, w: ((i / 3) % 2 == 1) ? 2'd2 : 2'd1};
`ifdef MUX_ARB_PRIO_A_EN
        u = 1'b0;
        da = 4'h1; db = 4'h2; dc = 4'h3; dd = 4'h4;
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b0111, 1'b1, 1'b1, 2'd0);
        step(4'b0110, 1'b1, 1'b1, 2'd1);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
`else
        // pure round robin, all requesters valid
        u = 1'b0;
        da = 4'h1; db = 4'h2; dc = 4'h3; dd = 4'h4;
        do_reset();
        for (int i = 0; i < 9; i++) run(t1[i]);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        // burst of three alternating between b and c
        u = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) run(t2[i]);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        // backpressure while holding c's word, then drain and refill together
        u = 1'b0;
        da = 4'h5; db = 4'h6; dc = 4'hA; dd = 4'h7;
        do_reset();
        step(4'b0100, 1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 5; i++) step(4'b0011, 1'b0, 1'b0, 2'd0);
        step(4'b0011, 1'b1, 1'b1, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        // pointer wrap: d first from reset pointer 3, then a
        do_reset();
        step(4'b1000, 1'b1, 1'b1, 2'd3);
        step(4'b0001, 1'b1, 1'b1, 2'd0);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
        // reset while full and stalled discards the word
        do_reset();
        step(4'b0001, 1'b1, 1'b1, 2'd0);
        step(4'b1111, 1'b0, 1'b0, 2'd0);
        vld = 4'b1111;
        ordy_r = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", {28'd0, o_rdy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        chk("rst_full_out_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_full_out_data", {28'd0, o_data}, 32'd0);
        chk("rst_full_sel", {30'd0, o_sel}, 32'd0);
        chk("rst_full_out_src", {30'd0, o_src}, 32'd0);
        step(4'b1111, 1'b1, 1'b1, 2'd0);
        step(4'b1111, 1'b1, 1'b1, 2'd1);
        step(4'b0000, 1'b1, 1'b0, 2'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_4bit_rr_arbiter.md
Name: mux_4bit_rr_arbiter

Overview:
- Shares one 4-bit 4:1 select path between four requesters (a, b, c, d), each with a valid/ready handshake.
- Round-robin arbitration with a configurable burst allowance.
- Winner's data is captured into a single-entry output register, presented with valid/ready.
- Sits in front of the 4-bit mux datapath. Drives the 2-bit select and reports the granted source alongside the data.

Parameters:
- DATA_W, 4, width of each requester's data and of out_data.
- MAX_BURST, 1, maximum consecutive grants to the same requester while it stays valid. Legal range 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester valid; bit0=a, bit1=b, bit2=c, bit3=d.
- req_ready  output  4  one-hot accept strobe; at most one bit high per cycle; combinational from state and req_valid.
- data_a, data_b, data_c, data_d  input  DATA_W  requester data.
- sel  output  2  select of the current grant; 0=a, 1=b, 2=c, 3=d; equals out_src.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  registered winner data.
- out_src  output  2  index of the requester that produced out_data.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following:
  - out_valid=0, out_data=0, out_src=0, sel=0.
  - last-grant pointer=3, so a is first in priority after reset.
  - burst_cnt=0.
  - req_ready is 0 while rst=1.
- Reset mid-transfer discards the held word without emitting it.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = EMPTY, or (FULL and out_ready). Draining and refilling in the same cycle gives full throughput, one word per cycle.
- Arbitration happens when can_accept and |req_valid. It is combinational in the cycle:
  - Burst hold: if req_valid[last] and burst_cnt < MAX_BURST, the winner is last.
  - Otherwise, the winner is the first valid index scanning last+1, last+2, ... modulo 4, wrapping from 3 to 0. Last is scanned last.
- Grant cycle:
  - req_ready[winner]=1.
  - On the edge: out_data <= data_winner, out_src <= winner, out_valid <= 1, last <= winner.
  - burst_cnt <= (winner==last) ? burst_cnt+1 : 1, saturating at 15.
- FULL and out_ready with no req_valid: go to EMPTY; out_data and out_src hold their values.
- FULL and not out_ready: hold out_data and out_src stable; req_ready=0.
- Latency: request accepted in cycle N appears on out_valid/out_data at cycle N+1.
- A requester drops valid: that is legal at any time when its ready is low. If last drops valid, burst_cnt no longer matters, and the next winner resets it to 1.
- MAX_BURST=1 gives pure round-robin. Each requester gets at most one grant per rotation while others are waiting.
- sel is the registered out_src, so the 4:1 datapath select is glitch-free.

Optional Feature:
- Macro: MUX_ARB_PRIO_A_EN.
- Defined: requester a (bit0) has absolute priority. If req_valid[0] and can_accept, a wins regardless of pointer or burst, and burst_cnt is not incremented for a. The pointer still updates to 0, so rotation resumes at b.
- Not defined: pure round-robin with burst as above. No other difference.

Test Plan:
- Reset, then all four valid, out_ready=1, MAX_BURST=1 -> out_src sequence 0,1,2,3,0,... one word per cycle. out_data follows data_a=4'h1, data_b=4'h2, data_c=4'h3, data_d=4'h4.
- MAX_BURST=3, b and c valid continuously -> out_src 1,1,1,2,2,2,1,... and req_ready one-hot on each grant.
- Backpressure: out_ready=0 for 5 cycles while FULL holding data_c=4'hA -> out_data=4'hA and out_src=2 stable, req_ready=0. Release -> the next winner is accepted in the same cycle as the drain.
- Only d valid after reset -> grant to d (scan wraps 0..3 from pointer 3). Then only a valid -> grant a, confirming wrap from 3 to 0.
- rst asserted while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, sel=0. The first post-reset grant goes to a when all are valid.
- MUX_ARB_PRIO_A_EN defined, a,b,c valid, a held valid -> out_src 0 every cycle. Drop a -> next grant is b (1).
